// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel array readout sequencer.
package pixel_readout_pkg;

    localparam int DATA_W  = 8;
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        TURN    = 3'd4,
        RSEL    = 3'd5,
        RHOLD   = 3'd6
    } rd_state_t;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_readout_ctrl_phase_timer.sv
// Loadable down-counter timing every fixed-length phase of the readout sequence.
// Loading N-1 on entry to a phase makes done fire in the N-th cycle of that phase.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Remaining-cycle counter; load wins over decrement and parks at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = en && (cnt_r == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Sequencer and readout master for the pixel array: erase, expose, ramp conversion, per-pixel readout stream.
// Build option PIXREAD_TESTPAT_EN replaces the captured bus value with a pixel-index test pattern.
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
#(
    parameter int ROW_NUM        = 2,
    parameter int COLUMN_NUM     = 2,
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 256,
    parameter int READ_SETUP     = 2,
    localparam int N             = ROW_NUM * COLUMN_NUM,
    localparam int IDX_W         = (clog2(ROW_NUM * COLUMN_NUM) < 1) ? 1 : clog2(ROW_NUM * COLUMN_NUM)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [N-1:0]      read,
    inout  wire  [DATA_W-1:0] data,
    output logic [DATA_W-1:0] pix_data,
    output logic [IDX_W-1:0]  pix_index,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy
);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    rd_state_t           state_r;
    rd_state_t           state_next_s;
    logic [IDX_W-1:0]    k_r;
    logic [IDX_W-1:0]    k_next_s;
    logic                tmr_load_s;
    logic [TIMER_W-1:0]  tmr_val_s;
    logic                tmr_en_s;
    logic                tmr_done_s;
    logic [DATA_W-1:0]   ramp_r;
    logic [DATA_W-1:0]   capture_s;
    logic [N-1:0]        read_next_s;

    logic                erase_r;
    logic                expose_r;
    logic                convert_r;
    logic                busy_r;
    logic [N-1:0]        read_r;
    logic                pix_valid_r;
    logic [DATA_W-1:0]   pix_data_r;
    logic [IDX_W-1:0]    pix_index_r;
    logic                pix_last_r;

    assign tmr_en_s = (state_r == ERASE) || (state_r == EXPOSE) ||
                      (state_r == CONVERT) || (state_r == RSEL);

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .done     (tmr_done_s)
    );

    // State and pixel-index registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            k_r     <= '0;
        end else begin
            state_r <= state_next_s;
            k_r     <= k_next_s;
        end
    end

    // Next-state logic; each phase entry preloads the shared timer with its length minus one.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = ERASE;
                    k_next_s     = '0;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TIMER_W'(ERASE_CYCLES - 1);
                end else begin
                    state_next_s = IDLE;
                end
            end
            ERASE: begin
                if (tmr_done_s) begin
                    state_next_s = EXPOSE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TIMER_W'(EXPOSE_CYCLES - 1);
                end else begin
                    state_next_s = ERASE;
                end
            end
            EXPOSE: begin
                if (tmr_done_s) begin
                    state_next_s = CONVERT;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TIMER_W'(CONVERT_CYCLES - 1);
                end else begin
                    state_next_s = EXPOSE;
                end
            end
            CONVERT: begin
                if (tmr_done_s) begin
                    state_next_s = TURN;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            TURN: begin
                state_next_s = RSEL;
                tmr_load_s   = 1'b1;
                tmr_val_s    = TIMER_W'(READ_SETUP - 1);
            end
            RSEL: begin
                if (tmr_done_s) begin
                    state_next_s = RHOLD;
                end else begin
                    state_next_s = RSEL;
                end
            end
            RHOLD: begin
                // pix_valid is always high here, so ready alone completes the handshake
                if (pix_ready) begin
                    if (k_r == K_LAST) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = RSEL;
                        k_next_s     = k_r + IDX_W'(1'b1);
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = TIMER_W'(READ_SETUP - 1);
                    end
                end else begin
                    state_next_s = RHOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One-hot select decode for the upcoming cycle.
    always_comb begin
        read_next_s = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_next_s == RSEL) && (k_next_s == IDX_W'(i))) begin
                read_next_s[i] = 1'b1;
            end else begin
                read_next_s[i] = 1'b0;
            end
        end
    end

    // Array control outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            erase_r   <= 1'b0;
            expose_r  <= 1'b0;
            convert_r <= 1'b0;
            busy_r    <= 1'b0;
            read_r    <= '0;
        end else begin
            erase_r   <= (state_next_s == ERASE);
            expose_r  <= (state_next_s == EXPOSE);
            convert_r <= (state_next_s == CONVERT);
            busy_r    <= (state_next_s != IDLE);
            read_r    <= read_next_s;
        end
    end

    // Ramp code: zero in the first conversion cycle, counting up while converting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ramp_r <= '0;
        end else if (state_r == CONVERT) begin
            ramp_r <= ramp_r + DATA_W'(1'b1);
        end else begin
            ramp_r <= '0;
        end
    end

    assign data = (state_r == CONVERT) ? ramp_r : {DATA_W{1'bz}};

`ifdef PIXREAD_TESTPAT_EN
    assign capture_s = DATA_W'(k_r) ^ 8'hA5;
`else
    assign capture_s = data;
`endif

    // Output stream register: capture on the last select cycle, drop valid only on handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= '0;
            pix_index_r <= '0;
            pix_last_r  <= 1'b0;
        end else if ((state_r == RSEL) && tmr_done_s) begin
            pix_valid_r <= 1'b1;
            pix_data_r  <= capture_s;
            pix_index_r <= k_r;
            pix_last_r  <= (k_r == K_LAST);
        end else if ((state_r == RHOLD) && pix_ready) begin
            pix_valid_r <= 1'b0;
        end else begin
            pix_valid_r <= pix_valid_r;
        end
    end

    assign erase     = erase_r;
    assign expose    = expose_r;
    assign convert   = convert_r;
    assign busy      = busy_r;
    assign read      = read_r;
    assign pix_valid = pix_valid_r;
    assign pix_data  = pix_data_r;
    assign pix_index = pix_index_r;
    assign pix_last  = pix_last_r;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: cycle-level timeline model, pixel bus model, random codes and ready.
module tb_pixel_readout_ctrl;

    localparam int E = 5;
    localparam int X = 255;
    localparam int C = 256;
    localparam int RS = 2;
    localparam int N = 4;
    localparam logic [7:0] PROBE = 8'hC3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic pix_ready = 1'b0;
    logic erase, expose, convert, pix_last, pix_valid, busy;
    logic [N-1:0] read;
    logic [7:0] pix_data;
    logic [1:0] pix_index;
    wire  [7:0] data;

    logic [7:0] pix_code [N];
    logic       bench_drv_s;
    logic [7:0] bench_val_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .erase     (erase),
        .expose    (expose),
        .convert   (convert),
        .read      (read),
        .data      (data),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_last  (pix_last),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy)
    );

    // Pixel array model: selected pixel drives its code; with nothing selected and no ramp, a probe value shows the bus was released.
    always_comb begin
        bench_drv_s = 1'b0;
        bench_val_s = 8'h00;
        if (read != '0) begin
            bench_drv_s = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (read[i]) bench_val_s = pix_code[i];
            end
        end else if (!convert) begin
            bench_drv_s = 1'b1;
            bench_val_s = PROBE;
        end
    end

    assign data = bench_drv_s ? bench_val_s : 8'bz;

    function automatic logic [7:0] exp_code(input int k);
`ifdef PIXREAD_TESTPAT_EN
        return 8'(k) ^ 8'hA5;
`else
        return pix_code[k];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        pix_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({erase, expose, convert, busy, pix_valid, read} !== 9'd0)
            $display("FAIL reset_ctrl got=%b want=%b", {erase, expose, convert, busy, pix_valid, read}, 9'd0);
        checks++;
        if ({pix_data, pix_index, pix_last} !== 11'd0)
            $display("FAIL reset_pix got=%h want=%h", {pix_data, pix_index, pix_last}, 11'd0);
        checks++;
        if (data !== PROBE) $display("FAIL reset_bus got=%h want=%h", data, PROBE);
        if ({erase, expose, convert, busy, pix_valid, read} !== 9'd0) errors++;
        if ({pix_data, pix_index, pix_last} !== 11'd0) errors++;
        if (data !== PROBE) errors++;
        reset_n = 1'b1;
        step();
    endtask

    // One full frame checked cycle by cycle against the phase timeline.
    task automatic test_frame(input string name, input bit fixed37, input int hold_k,
                              input int hold_len, input bit rand_ready, input bit poke);
        int t, k, pt0, held;
        bit done, rdy, e_v;
        logic [N-1:0] e_rd;
        logic [4+N:0] e_ctrl, a_ctrl;
        for (int i = 0; i < N; i++) pix_code[i] = 8'($urandom_range(0, 255));
        if (fixed37) pix_code[2] = 8'h37;
        start = 1'b1;
        pix_ready = 1'b0;
        step();
        start = 1'b0;
        t = 1; k = 0; pt0 = E + X + C + 2; held = 0; done = 1'b0;
        while (!done && t < 4000) begin
            e_rd = '0;
            e_v = 1'b0;
            if (t >= pt0) begin
                if (t - pt0 < RS) e_rd[k] = 1'b1;
                else e_v = 1'b1;
            end
            e_ctrl = {(t <= E), (t > E && t <= E + X), (t > E + X && t <= E + X + C), 1'b1, e_v, e_rd};
            a_ctrl = {erase, expose, convert, busy, pix_valid, read};
            checks++;
            if (a_ctrl !== e_ctrl) begin
                errors++;
                $display("FAIL %s ctrl t=%0d got=%b want=%b", name, t, a_ctrl, e_ctrl);
            end
            if (t > E + X && t <= E + X + C) begin
                checks++;
                if (data !== 8'(t - E - X - 1)) begin
                    errors++;
                    $display("FAIL %s ramp t=%0d got=%h want=%h", name, t, data, 8'(t - E - X - 1));
                end
            end else if (e_rd == '0) begin
                checks++;
                if (data !== PROBE) begin
                    errors++;
                    $display("FAIL %s bus_release t=%0d got=%h want=%h", name, t, data, PROBE);
                end
            end
            if (e_v) begin
                checks++;
                if ({pix_data, pix_index, pix_last} !== {exp_code(k), 2'(k), (k == N - 1)}) begin
                    errors++;
                    $display("FAIL %s pixel k=%0d got=%h/%0d/%b want=%h/%0d/%b", name, k,
                             pix_data, pix_index, pix_last, exp_code(k), k, (k == N - 1));
                end
            end
            checks++;
            if (($countones(read) > 1) || (convert && (read != '0))) begin
                errors++;
                $display("FAIL %s contention t=%0d got read=%b convert=%b", name, t, read, convert);
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (e_v && k == hold_k && held < hold_len) begin
                rdy = 1'b0;
                held++;
            end
            pix_ready = rdy;
            start = poke && ((t == E + 10) || (e_v && k == 0));
            if (e_v && rdy) begin
                if (k == N - 1) done = 1'b1;
                else begin
                    k++;
                    pt0 = t + 1;
                end
            end
            step();
            t++;
        end
        start = 1'b0;
        pix_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got=%0d pixels want=%0d", name, k, N);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({erase, expose, convert, busy, pix_valid, read} !== 9'd0) begin
                errors++;
                $display("FAIL %s idle got=%b want=%b", name, {erase, expose, convert, busy, pix_valid, read}, 9'd0);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_convert();
        int t;
        start = 1'b1;
        step();
        start = 1'b0;
        for (t = 1; t < E + X + 1 + 100; t++) step();
        checks++;
        if (data !== 8'd100 || convert !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ramp got=%h/%b want=%h/1", data, convert, 8'd100);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if ({erase, expose, convert, busy, pix_valid, read} !== 9'd0) begin
            errors++;
            $display("FAIL midrst_ctrl got=%b want=%b", {erase, expose, convert, busy, pix_valid, read}, 9'd0);
        end
        checks++;
        if ({pix_data, pix_index, pix_last} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_pix got=%h want=%h", {pix_data, pix_index, pix_last}, 11'd0);
        end
        checks++;
        if (data !== PROBE) begin
            errors++;
            $display("FAIL midrst_bus got=%h want=%h", data, PROBE);
        end
        repeat (3) step();
        checks++;
        if ({busy, pix_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_quiet got=%b want=%b", {busy, pix_valid}, 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_frame("basic", 1'b1, -1, 0, 1'b0, 1'b0);
        test_frame("hold", 1'b0, 1, 10, 1'b0, 1'b0);
        test_reset_mid_convert();
        test_frame("after_reset", 1'b0, -1, 0, 1'b0, 1'b0);
        test_frame("start_ignored", 1'b0, -1, 0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) test_frame("random", 1'b0, -1, 0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
